alu_mul_ctrl: RTL and testbench



---
 rtl/alu_mul_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_mul_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_ctrl.sv
// Shift-add 16x16 unsigned multiply sequencer that borrows the shared ALU via alu_req/alu_gnt.
// Optional product flags output enabled with `define ALU_MUL_FLAGS_EN.
module alu_mul_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] prod,
   output logic        alu_req,
   input  logic        alu_gnt,
   output logic [2:0]  alu_op,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   input  logic [15:0] alu_res,
   input  logic [3:0]  alu_flags
`ifdef ALU_MUL_FLAGS_EN
   ,
   output logic [3:0]  flags
`endif
);

   // state | meaning
   // IDLE  | waiting for start, product held
   // RUN   | ALU requested, one shift-add step per granted cycle
   // DONE  | product valid, done pulse, start accepted as in IDLE
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] mc, hi, lo;
   logic [4:0]  cnt;
   logic        load, step, last;
   logic [15:0] hi_nxt, lo_nxt;
   logic        unused_alu_flags;

   assign unused_alu_flags = ^alu_flags[3:1];
   assign alu_op = 3'b000;
   assign prod   = {hi, lo};
   assign last   = (cnt == 5'd15);
   assign hi_nxt = {alu_flags[0], alu_res[15:1]};
   assign lo_nxt = {alu_res[0], lo[15:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      alu_req = 1'b0;
      alu_a   = 16'h0000;
      alu_b   = 16'h0000;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy    = 1'b1;
            alu_req = 1'b1;
            alu_a   = hi;
            alu_b   = lo[0] ? mc : 16'h0000;
            if (alu_gnt) begin
               step = 1'b1;
               if (last) state_d = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mc  <= 16'h0000;
         hi  <= 16'h0000;
         lo  <= 16'h0000;
         cnt <= 5'd0;
      end else if (load) begin
         mc  <= op_a;
         hi  <= 16'h0000;
         lo  <= op_b;
         cnt <= 5'd0;
      end else if (step) begin
         hi  <= hi_nxt;
         lo  <= lo_nxt;
         cnt <= cnt + 5'd1;
      end
   end

`ifdef ALU_MUL_FLAGS_EN
   logic [31:0] prod_nxt;
   logic        ovf;

   assign prod_nxt = {hi_nxt, lo_nxt};
   assign ovf      = (hi_nxt != 16'h0000);

   // Captured from the final step's result so flags line up with prod in DONE.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         flags <= 4'b0000;
      end else if (step && last) begin
         flags <= {ovf, (prod_nxt == 32'h0), prod_nxt[31], ovf};
      end
   end
`endif

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Scoreboard bench for alu_mul_ctrl: directed multiplies with a combinational ALU model.
module tb_alu_mul_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, alu_gnt;
   logic [15:0] op_a, op_b;
   logic        busy, done, alu_req;
   logic [31:0] prod;
   logic [2:0]  alu_op;
   logic [15:0] alu_a, alu_b, alu_res;
   logic [3:0]  alu_flags;
   logic [3:0]  flags;
   logic        alu_c;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] p;
      logic [3:0]  f;
      int          acc;
      int          lat;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign {alu_c, alu_res} = {1'b0, alu_a} + {1'b0, alu_b};
   assign alu_flags = {1'b0, (alu_res == 16'h0), alu_res[15], alu_c};

`ifndef ALU_MUL_FLAGS_EN
   assign flags = 4'b0000;
`endif

   alu_mul_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op_a      (op_a),
      .op_b      (op_b),
      .busy      (busy),
      .done      (done),
      .prod      (prod),
      .alu_req   (alu_req),
      .alu_gnt   (alu_gnt),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_res   (alu_res),
      .alu_flags (alu_flags)
`ifdef ALU_MUL_FLAGS_EN
      ,
      .flags     (flags)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic logic [3:0] flags_of(input logic [31:0] p);
      logic o;
      o = (p[31:16] != 16'h0);
      return {o, (p == 32'h0), p[31], o};
   endfunction

   function automatic exp_t mk(input logic [31:0] p, input int acc, input int lat);
      exp_t e;
      e.p = p; e.f = flags_of(p); e.acc = acc; e.lat = lat;
      return e;
   endfunction

   // Monitor: pops an expectation on every done pulse.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("prod", prod, e.p);
            chk("latency", cyc - e.acc + 1, e.lat);
`ifdef ALU_MUL_FLAGS_EN
            chk("flags", {28'h0, flags}, {28'h0, e.f});
`endif
         end
      end
   end

   task automatic issue(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] p, input int lat);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      q.push_back(mk(p, cyc + 1, lat));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL %s timeout actual=no_done required=done", nm);
      end
   endtask

   initial begin
      logic [15:0] sa, sb;
      logic [31:0] sp;
      int          acc1;
      bit          seen;

      rst = 1'b1; start = 1'b0; alu_gnt = 1'b1; op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_req", {31'h0, alu_req}, 32'd0);
      chk("rst_prod", prod, 32'd0);
      chk("rst_alu_a", {16'h0, alu_a}, 32'd0);
      chk("rst_alu_b", {16'h0, alu_b}, 32'd0);
      chk("alu_op", {29'h0, alu_op}, 32'd0);
      rst = 1'b0;

      issue(16'd3, 16'd5, 32'h0000000F, 17);
      chk("run_busy", {31'h0, busy}, 32'd1);
      chk("run_req", {31'h0, alu_req}, 32'd1);
      wait_done("basic");

      issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17);
      wait_done("carry");

      issue(16'h1234, 16'h0100, 32'h00123400, 22);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         alu_gnt = 1'b0;
         sa = alu_a; sb = alu_b; sp = prod;
         @(posedge clk);
         #1;
         chk("stall_alu_a", {16'h0, alu_a}, {16'h0, sa});
         chk("stall_alu_b", {16'h0, alu_b}, {16'h0, sb});
         chk("stall_prod", prod, sp);
         @(negedge clk);
         alu_gnt = 1'b1;
         @(negedge clk);
      end
      wait_done("stall");

      issue(16'h00FF, 16'h0101, 32'h0000FFFF, 17);
      repeat (4) @(negedge clk);
      op_a = 16'd7; op_b = 16'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_ignore", {31'h0, busy}, 32'd1);
      wait_done("ignore");
      issue(16'h0000, 16'hABCD, 32'h00000000, 17);
      wait_done("zero");

      @(negedge clk);
      op_a = 16'h1111; op_b = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_busy", {31'h0, busy}, 32'd0);
      chk("mid_rst_req", {31'h0, alu_req}, 32'd0);
      chk("mid_rst_prod", prod, 32'd0);
      chk("mid_rst_done", {31'h0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      chk("no_done_after_rst", {31'h0, seen}, 32'd0);
      issue(16'd2, 16'd2, 32'd4, 17);
      wait_done("after_rst");

      @(negedge clk);
      op_a = 16'd6; op_b = 16'd7; start = 1'b1;
      acc1 = cyc + 1;
      q.push_back(mk(32'd42, acc1, 17));
      @(negedge clk);
      op_a = 16'd10; op_b = 16'd10;
      q.push_back(mk(32'd100, acc1 + 17, 17));
      wait_done("b2b_first");
      @(negedge clk);
      chk("b2b_busy", {31'h0, busy}, 32'd1);
      start = 1'b0;
      wait_done("b2b_second");

      repeat (5) @(negedge clk);
      chk("queue_empty", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
